mem_ctrl: RTL and testbench

//  Byte-serial memory controller directly upstream of the 8-bit synchronous on-board RAM.

---
 rtl/mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl
//   Byte-serial controller in front of the 8-bit synchronous on-board RAM.
//   It arbitrates the instruction-fetch port (32-bit reads) and the load/store
//   port (1/2/4-byte reads and writes). It issues one RAM byte access per
//   cycle in little-endian order and returns the assembled word together with
//   a one-cycle done pulse. Every output comes straight from a register.
//
// Ports
//   clk_in, rst_in          clock, asynchronous active-high reset
//   rdy_in                  global ready, 0 freezes the whole controller
//   clear_in                pipeline flush, aborts an in-flight fetch only
//   if_req_in/if_addr_in    fetch request (level) and byte address
//   if_done_out/if_data_out fetch done pulse and fetched word
//   ls_req_in/ls_we_in      load/store request (level), 1 = store
//   ls_size_in              0 = byte, 1 = half, 2/3 = word
//   ls_addr_in/ls_wdata_in  load/store byte address and store data
//   ls_done_out             load/store done pulse
//   ls_rdata_out            zero-extended load data
//   ram_en_out/ram_r_nw_out RAM enable and read(1)/write(0)
//   ram_a_out/ram_d_out     RAM byte address and write data
//   ram_d_in                RAM read data, 0 whenever ram_en_out is 0

module mem_ctrl #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_in,
  input  logic                  if_req_in,
  input  logic [31:0]           if_addr_in,
  output logic                  if_done_out,
  output logic [31:0]           if_data_out,
  input  logic                  ls_req_in,
  input  logic                  ls_we_in,
  input  logic [1:0]            ls_size_in,
  input  logic [31:0]           ls_addr_in,
  input  logic [31:0]           ls_wdata_in,
  output logic                  ls_done_out,
  output logic [31:0]           ls_rdata_out,
  output logic                  ram_en_out,
  output logic                  ram_r_nw_out,
  output logic [ADDR_WIDTH-1:0] ram_a_out,
  output logic [7:0]            ram_d_out,
  input  logic [7:0]            ram_d_in
);

  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  state_t                r_state, w_state;
  logic [2:0]            r_step, w_step;
  logic [2:0]            r_len, w_len;
  logic [23:0]           r_wdataHi, w_wdataHi;
  logic [31:0]           r_buf, w_buf;
  logic                  r_ifDone, w_ifDone;
  logic [31:0]           r_ifData, w_ifData;
  logic                  r_lsDone, w_lsDone;
  logic [31:0]           r_lsRdata, w_lsRdata;
  logic                  r_ramEn, w_ramEn;
  logic                  r_ramRnw, w_ramRnw;
  logic [ADDR_WIDTH-1:0] r_ramA, w_ramA;
  logic [7:0]            r_ramD, w_ramD;
  logic                  w_abort;
  logic                  w_unusedBits;

  // Request addresses are truncated to the RAM width; the upper bits are
  // intentionally dropped.
  assign w_unusedBits = ^{if_addr_in[31:ADDR_WIDTH], ls_addr_in[31:ADDR_WIDTH]};

  // Next-state and next-output logic. r_step counts cycles since the first
  // access cycle. For reads, the byte presented at step k comes back from the
  // synchronous RAM one cycle later, so byte k is captured while at step k+1.
  // The last address is held one extra cycle with enable still high because
  // the RAM gates its output with enable. With rdy_in low every default holds,
  // which freezes state, counters and outputs.
  always_comb begin
    w_state   = r_state;
    w_step    = r_step;
    w_len     = r_len;
    w_wdataHi = r_wdataHi;
    w_buf     = r_buf;
    w_ifDone  = r_ifDone;
    w_ifData  = r_ifData;
    w_lsDone  = r_lsDone;
    w_lsRdata = r_lsRdata;
    w_ramEn   = r_ramEn;
    w_ramRnw  = r_ramRnw;
    w_ramA    = r_ramA;
    w_ramD    = r_ramD;
    w_abort   = 1'b0;
    if (rdy_in) begin
      w_ifDone = 1'b0;
      w_lsDone = 1'b0;
      case (r_state)
        IDLE: begin
          // Nothing is accepted while a done pulse is showing, so the
          // requester has a cycle to drop its level request.
          if (!r_ifDone && !r_lsDone) begin
            if (ls_req_in) begin
              w_state   = ls_we_in ? LS_WR : LS_RD;
              w_step    = 3'd0;
              w_buf     = '0;
              w_ramEn   = 1'b1;
              w_ramRnw  = !ls_we_in;
              w_ramA    = ls_addr_in[ADDR_WIDTH-1:0];
              w_ramD    = ls_we_in ? ls_wdata_in[7:0] : 8'h00;
              w_wdataHi = ls_wdata_in[31:8];
              case (ls_size_in)
                2'd0:    w_len = 3'd1;
                2'd1:    w_len = 3'd2;
                default: w_len = 3'd4;
              endcase
            end else if (if_req_in && !clear_in) begin
              w_state  = IF_RD;
              w_step   = 3'd0;
              w_len    = 3'd4;
              w_buf    = '0;
              w_ramEn  = 1'b1;
              w_ramRnw = 1'b1;
              w_ramA   = if_addr_in[ADDR_WIDTH-1:0];
              w_ramD   = 8'h00;
            end
          end
        end
        IF_RD, LS_RD: begin
          // A flush kills a fetch, except on its final edge where the
          // done pulse is already committed.
          w_abort = (r_state == IF_RD) && clear_in && (r_step != r_len);
          if (w_abort) begin
            w_state = IDLE;
            w_ramEn = 1'b0;
          end else begin
            w_step = r_step + 3'd1;
            case (r_step)
              3'd1:    w_buf[7:0]   = ram_d_in;
              3'd2:    w_buf[15:8]  = ram_d_in;
              3'd3:    w_buf[23:16] = ram_d_in;
              3'd4:    w_buf[31:24] = ram_d_in;
              default: ;
            endcase
            if (r_step == r_len) begin
              w_state = IDLE;
              w_ramEn = 1'b0;
              if (r_state == IF_RD) begin
                w_ifDone = 1'b1;
                w_ifData = w_buf;
              end else begin
                w_lsDone  = 1'b1;
                w_lsRdata = w_buf;
              end
            end else if (w_step != r_len) begin
              w_ramA = r_ramA + ADDR_ONE;
            end
          end
        end
        LS_WR: begin
          w_step = r_step + 3'd1;
          if (w_step == r_len) begin
            w_state  = IDLE;
            w_ramEn  = 1'b0;
            w_ramRnw = 1'b1;
            w_ramD   = 8'h00;
            w_lsDone = 1'b1;
          end else begin
            w_ramA = r_ramA + ADDR_ONE;
            case (w_step)
              3'd1:    w_ramD = r_wdataHi[7:0];
              3'd2:    w_ramD = r_wdataHi[15:8];
              default: w_ramD = r_wdataHi[23:16];
            endcase
          end
        end
        default: w_state = IDLE;
      endcase
    end
  end

  // State and output registers; reset leaves the RAM interface idle in read
  // mode and clears the returned data.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state   <= IDLE;
      r_step    <= 3'd0;
      r_len     <= 3'd0;
      r_wdataHi <= '0;
      r_buf     <= '0;
      r_ifDone  <= 1'b0;
      r_ifData  <= '0;
      r_lsDone  <= 1'b0;
      r_lsRdata <= '0;
      r_ramEn   <= 1'b0;
      r_ramRnw  <= 1'b1;
      r_ramA    <= '0;
      r_ramD    <= 8'h00;
    end else begin
      r_state   <= w_state;
      r_step    <= w_step;
      r_len     <= w_len;
      r_wdataHi <= w_wdataHi;
      r_buf     <= w_buf;
      r_ifDone  <= w_ifDone;
      r_ifData  <= w_ifData;
      r_lsDone  <= w_lsDone;
      r_lsRdata <= w_lsRdata;
      r_ramEn   <= w_ramEn;
      r_ramRnw  <= w_ramRnw;
      r_ramA    <= w_ramA;
      r_ramD    <= w_ramD;
    end
  end

  assign if_done_out  = r_ifDone;
  assign if_data_out  = r_ifData;
  assign ls_done_out  = r_lsDone;
  assign ls_rdata_out = r_lsRdata;
  assign ram_en_out   = r_ramEn;
  assign ram_r_nw_out = r_ramRnw;
  assign ram_a_out    = r_ramA;
  assign ram_d_out    = r_ramD;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl
//   Testbench for mem_ctrl with a behavioural synchronous 8-bit RAM, a
//   reference byte memory and scoreboards for fetch and load/store results.

module tb_mem_ctrl;

  localparam int AW = 17;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } lsExp_t;

  logic          clk = 1'b0;
  logic          rst, rdy, clear;
  logic          ifReq, lsReq, lsWe;
  logic [1:0]    lsSize;
  logic [31:0]   ifAddr, lsAddr, lsWdata;
  logic          ifDone, lsDone, ramEn, ramRnw;
  logic [31:0]   ifData, lsRdata;
  logic [AW-1:0] ramA;
  logic [7:0]    ramDout, ramDin;

  logic [7:0]    ram    [0:(1<<AW)-1];
  logic [7:0]    refMem [0:(1<<AW)-1];
  logic [7:0]    ramQ;
  logic          bdWe;
  logic [AW-1:0] bdAddr;
  logic [7:0]    bdData;

  logic [31:0]   ifQ[$];
  lsExp_t        lsQ[$];
  lsExp_t        monE;

  int nChecks = 0;
  int nFails  = 0;

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
    .if_req_in(ifReq), .if_addr_in(ifAddr), .if_done_out(ifDone), .if_data_out(ifData),
    .ls_req_in(lsReq), .ls_we_in(lsWe), .ls_size_in(lsSize), .ls_addr_in(lsAddr),
    .ls_wdata_in(lsWdata), .ls_done_out(lsDone), .ls_rdata_out(lsRdata),
    .ram_en_out(ramEn), .ram_r_nw_out(ramRnw), .ram_a_out(ramA), .ram_d_out(ramDout),
    .ram_d_in(ramDin)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with a backdoor port for preloading; output gated by enable.
  always @(posedge clk) begin
    if (bdWe) ram[bdAddr] <= bdData;
    else if (ramEn) begin
      if (!ramRnw) ram[ramA] <= ramDout;
      ramQ <= ram[ramA];
    end
  end
  assign ramDin = ramEn ? ramQ : 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %08h expected %08h", tag, actual, expected);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] addr, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = refMem[addr[AW-1:0] + AW'(i)];
    return r;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    refMem[a] = d;
    bdWe = 1'b1; bdAddr = a; bdData = d;
    @(posedge clk); #1;
    bdWe = 1'b0;
  endtask

  // Raise a request and push its expected result to the scoreboard.
  task automatic applyStimulus(input logic isFetch, input logic we, input logic [1:0] size,
                               input logic [31:0] addr, input logic [31:0] wdata, input logic track);
    lsExp_t e;
    int n;
    if (isFetch) begin
      ifReq = 1'b1; ifAddr = addr;
      if (track) ifQ.push_back(modelRead(addr, 4));
    end else begin
      n = sizeBytes(size);
      lsReq = 1'b1; lsWe = we; lsSize = size; lsAddr = addr; lsWdata = wdata;
      if (we) begin
        for (int i = 0; i < n; i++) refMem[addr[AW-1:0] + AW'(i)] = wdata[8*i +: 8];
        e.chk = 1'b0; e.data = '0;
      end else begin
        e.chk = 1'b1; e.data = modelRead(addr, n);
      end
      if (track) lsQ.push_back(e);
    end
  endtask

  task automatic waitDone(input logic isFetch, input int budget, output int cycles);
    logic seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      seen = isFetch ? ifDone : lsDone;
    end
    if (!seen) checkOutput(isFetch ? "if_done_timeout" : "ls_done_timeout", 32'd0, 32'd1);
    if (isFetch) ifReq = 1'b0; else lsReq = 1'b0;
  endtask

  task automatic checkRam(input string tag, input logic [AW-1:0] base);
    for (int i = 0; i < 4; i++)
      checkOutput(tag, 32'(ram[base + AW'(i)]), 32'(refMem[base + AW'(i)]));
  endtask

  // Scoreboard: compare each done pulse with the oldest expected result.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifDone) begin
        if (ifQ.size() == 0) checkOutput("if_unexpected_done", 32'(ifDone), 32'd0);
        else checkOutput("if_data", ifData, ifQ.pop_front());
      end
      if (lsDone) begin
        if (lsQ.size() == 0) checkOutput("ls_unexpected_done", 32'(lsDone), 32'd0);
        else begin
          monE = lsQ.pop_front();
          if (monE.chk) checkOutput("ls_rdata", lsRdata, monE.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic [31:0] w;
    int offTab[8] = '{0, 1, 1, 1, 1, 2, 3, 3};
    logic sawDone;
    rst = 1'b0; rdy = 1'b1; clear = 1'b0; ifReq = 1'b0; lsReq = 1'b0; lsWe = 1'b0;
    lsSize = 2'd0; ifAddr = '0; lsAddr = '0; lsWdata = '0; bdWe = 1'b0; bdAddr = '0; bdData = '0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    preload(17'h00100, 8'h11); preload(17'h00101, 8'h22);
    preload(17'h00102, 8'h33); preload(17'h00103, 8'h44);
    preload(17'h1FFFF, 8'hA1); preload(17'h00000, 8'hB2);
    preload(17'h00001, 8'hC3); preload(17'h00002, 8'hD4);

    // Reset state
    @(negedge clk);
    checkOutput("rst_en", 32'(ramEn), 32'd0);
    checkOutput("rst_rnw", 32'(ramRnw), 32'd1);
    checkOutput("rst_a", 32'(ramA), 32'd0);
    checkOutput("rst_d", 32'(ramDout), 32'd0);
    checkOutput("rst_done", 32'({ifDone, lsDone}), 32'd0);
    checkOutput("rst_data", ifData | lsRdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: word fetch with cycle-exact enable, address and done timing
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_en%0d", k), 32'(ramEn), (k < 5) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t1_done%0d", k), 32'(ifDone), (k == 5) ? 32'd1 : 32'd0);
      if (k < 5) begin
        checkOutput($sformatf("t1_a%0d", k), 32'(ramA), 32'h100 + 32'((k < 3) ? k : 3));
        checkOutput($sformatf("t1_rnw%0d", k), 32'(ramRnw), 32'd1);
      end
    end
    ifReq = 1'b0;

    // 2: word store, then byte and half loads from inside it
    w = 32'hDEADBEEF;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h200, w, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_en%0d", k), 32'(ramEn), (k < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2_done%0d", k), 32'(lsDone), (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) begin
        checkOutput($sformatf("t2_rnw%0d", k), 32'(ramRnw), 32'd0);
        checkOutput($sformatf("t2_d%0d", k), 32'(ramDout), 32'(w[8*k +: 8]));
      end
    end
    lsReq = 1'b0;
    checkRam("t2_ram", 17'h00200);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h202, 32'h0, 1'b1);
    waitDone(1'b0, 30, n);
    checkOutput("t2_byte_lat", 32'(n), 32'd4);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'd1, 32'h201, 32'h0, 1'b1);
    waitDone(1'b0, 30, n);
    checkOutput("t2_half_lat", 32'(n), 32'd5);

    // 3: simultaneous requests, load/store wins, fetch follows after one idle cycle
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h200, 32'h0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("t3_first_a", 32'(ramA), 32'h100);
    waitDone(1'b0, 30, n);
    waitDone(1'b1, 30, n);
    checkOutput("t3_if_lat", 32'(n), 32'd7);

    // 4: flush mid-fetch aborts it; flush in idle holds off a pending fetch
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    clear = 1'b1; ifReq = 1'b0;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    checkOutput("t4_abort_en", 32'(ramEn), 32'd0);
    sawDone = ifDone;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      sawDone = sawDone | ifDone;
    end
    checkOutput("t4_no_done", 32'(sawDone), 32'd0);
    @(posedge clk); #1;
    clear = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    checkOutput("t4_idle_hold_en", 32'(ramEn), 32'd0);
    waitDone(1'b1, 30, n);
    checkOutput("t4_if_lat", 32'(n), 32'd6);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h300, 32'h12345678, 1'b1);
    waitDone(1'b0, 30, n);
    checkOutput("t4_st_lat", 32'(n), 32'd6);
    checkRam("t4_ram", 17'h00300);

    // 5: three-cycle freeze during a word store
    w = 32'hCAFEF00D;
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h400, w, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_en%0d", k), 32'(ramEn), (k < 7) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t5_done%0d", k), 32'(lsDone), (k == 7) ? 32'd1 : 32'd0);
      if (k < 7) begin
        checkOutput($sformatf("t5_a%0d", k), 32'(ramA), 32'h400 + 32'(offTab[k]));
        checkOutput($sformatf("t5_d%0d", k), 32'(ramDout), 32'(w[8*offTab[k] +: 8]));
        checkOutput($sformatf("t5_rnw%0d", k), 32'(ramRnw), 32'd0);
      end
      if (k == 0) begin @(posedge clk); #1 rdy = 1'b0; end
      if (k == 3) begin @(posedge clk); #1 rdy = 1'b1; end
    end
    lsReq = 1'b0;
    checkRam("t5_ram", 17'h00400);

    // 6: fetch wrapping the top of the RAM, upper address bits ignored
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h0003FFFF, 32'h0, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_a%0d", k), 32'(ramA), (32'h1FFFF + 32'(k)) & 32'h1FFFF);
    end
    waitDone(1'b1, 30, n);

    // 6b: reset in the middle of a fetch
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checkOutput("t6_rst_en", 32'(ramEn), 32'd0);
    checkOutput("t6_rst_rnw", 32'(ramRnw), 32'd1);
    checkOutput("t6_rst_a", 32'(ramA), 32'd0);
    checkOutput("t6_rst_data", ifData, 32'd0);
    ifReq = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_idle_en", 32'(ramEn), 32'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h100, 32'h0, 1'b1);
    waitDone(1'b1, 30, n);

    @(posedge clk); #1;
    checkOutput("sb_if_empty", 32'(ifQ.size()), 32'd0);
    checkOutput("sb_ls_empty", 32'(lsQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
